// File: rtl/traffic_light_pkg.sv
// Shared types for the traffic light monitor: light codes, the per-direction
// tracker state, the debug view of both trackers and the cycle-counter width.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        RED     = 2'b00,
        YELLOW  = 2'b01,
        GREEN   = 2'b10,
        INVALID = 2'b11
    } light_t;

    typedef enum logic [1:0] {
        TRK_SYNC   = 2'b00,
        TRK_RED    = 2'b01,
        TRK_GREEN  = 2'b10,
        TRK_YELLOW = 2'b11
    } track_state_t;

    typedef struct packed {
        track_state_t ns_state;
        track_state_t ew_state;
    } monitor_dbg_t;

    localparam int CYCLE_CNT_W = 16;

    // The only colour a phase may legally hand over to.
    function automatic light_t next_light(input light_t cur);
        case (cur)
            GREEN:   next_light = YELLOW;
            YELLOW:  next_light = RED;
            RED:     next_light = GREEN;
            default: next_light = INVALID;
        endcase
    endfunction

    // Tracker state that corresponds to a valid sampled colour.
    function automatic track_state_t state_of(input light_t cur);
        case (cur)
            RED:     state_of = TRK_RED;
            GREEN:   state_of = TRK_GREEN;
            YELLOW:  state_of = TRK_YELLOW;
            default: state_of = TRK_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/light_phase_tracker.sv
// Follows one direction's light code: measures phase dwell, flags illegal
// colour changes and badly timed phases, and counts completed
// GREEN->YELLOW->RED sequences. Error pulses are registered on the edge
// that samples the offending code; err_next is the same information one
// step earlier so the top can fold it into the sticky flag on that edge.
module light_phase_tracker
    import traffic_light_pkg::*;
#(
    parameter int YELLOW_CYCLES = 2,
    parameter int MIN_GREEN     = 3,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             light,
    output logic                   seq_err,
    output logic                   tim_err,
    output logic                   err_next,
    output logic [CYCLE_CNT_W-1:0] cycles,
    output track_state_t           state
);

    light_t           prev;
    logic [CNT_W-1:0] dwell;
    logic             first_phase;
    logic             yellow_from_green;

    light_t code;
    logic   synced;
    logic   changed;
    logic   legal;
    logic   seq_d;
    logic   tim_d;
    logic   count_d;

    // Decode the sampled code against the outgoing phase.
    always_comb begin
        code    = light_t'(light);
        synced  = (state != TRK_SYNC);
        changed = 1'b0;
        legal   = 1'b0;
        seq_d   = 1'b0;
        tim_d   = 1'b0;
        count_d = 1'b0;
        if (code == INVALID) begin
            seq_d = 1'b1;
        end else if (synced && (code != prev)) begin
            changed = 1'b1;
            legal   = (code == next_light(prev));
            seq_d   = !legal;
            // Illegal changes report only the sequence error; the partial
            // phase seen right after sync is never timed.
            if (legal && !first_phase) begin
                if ((prev == YELLOW) && (dwell != CNT_W'(YELLOW_CYCLES)))
                    tim_d = 1'b1;
                if ((prev == GREEN) && (dwell < CNT_W'(MIN_GREEN)))
                    tim_d = 1'b1;
            end
            count_d = legal && (prev == YELLOW) && yellow_from_green;
        end
        err_next = seq_d | tim_d;
    end

    // Tracker FSM with its phase history, error pulses and cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= TRK_SYNC;
            prev              <= RED;
            dwell             <= '0;
            first_phase       <= 1'b1;
            yellow_from_green <= 1'b0;
            seq_err           <= 1'b0;
            tim_err           <= 1'b0;
            cycles            <= '0;
        end else begin
            seq_err <= seq_d;
            tim_err <= tim_d;
            if (count_d && (cycles != '1))
                cycles <= cycles + CYCLE_CNT_W'(1);

            if (code == INVALID) begin
                state             <= TRK_SYNC;
                prev              <= RED;
                dwell             <= '0;
                first_phase       <= 1'b1;
                yellow_from_green <= 1'b0;
            end else if (!synced) begin
                state             <= state_of(code);
                prev              <= code;
                dwell             <= CNT_W'(1);
                first_phase       <= 1'b1;
                yellow_from_green <= 1'b0;
            end else if (changed) begin
                state             <= state_of(code);
                prev              <= code;
                dwell             <= CNT_W'(1);
                first_phase       <= 1'b0;
                yellow_from_green <= legal && (prev == GREEN);
            end else if (dwell != '1) begin
                dwell <= dwell + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker beside the traffic light controller. Two phase trackers
// handle sequence/timing/cycle counting per direction; this level adds the
// cross-direction conflict check and the sticky error flag. The dbg output
// shows both tracker states.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int YELLOW_CYCLES = 2,
    parameter int MIN_GREEN     = 3,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             ns_light,
    input  logic [1:0]             ew_light,
    input  logic                   clear_err,
    output logic                   err_conflict,
    output logic                   err_sequence,
    output logic                   err_timing,
    output logic                   err_sticky,
    output logic [CYCLE_CNT_W-1:0] ns_cycles,
    output logic [CYCLE_CNT_W-1:0] ew_cycles,
    output monitor_dbg_t           dbg
);

    logic ns_seq, ns_tim, ns_next;
    logic ew_seq, ew_tim, ew_next;
    logic conflict_d;

    light_phase_tracker #(
        .YELLOW_CYCLES(YELLOW_CYCLES),
        .MIN_GREEN    (MIN_GREEN),
        .CNT_W        (CNT_W)
    ) u_ns (
        .clk     (clk),
        .reset_n (reset_n),
        .light   (ns_light),
        .seq_err (ns_seq),
        .tim_err (ns_tim),
        .err_next(ns_next),
        .cycles  (ns_cycles),
        .state   (dbg.ns_state)
    );

    light_phase_tracker #(
        .YELLOW_CYCLES(YELLOW_CYCLES),
        .MIN_GREEN    (MIN_GREEN),
        .CNT_W        (CNT_W)
    ) u_ew (
        .clk     (clk),
        .reset_n (reset_n),
        .light   (ew_light),
        .seq_err (ew_seq),
        .tim_err (ew_tim),
        .err_next(ew_next),
        .cycles  (ew_cycles),
        .state   (dbg.ew_state)
    );

    // Any non-RED pair conflicts, INVALID included, whether synced or not.
    assign conflict_d   = (light_t'(ns_light) != RED) && (light_t'(ew_light) != RED);
    assign err_sequence = ns_seq | ew_seq;
    assign err_timing   = ns_tim | ew_tim;

    // Register the conflict pulse; sticky takes new errors over a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_conflict <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            err_conflict <= conflict_d;
            err_sticky   <= conflict_d | ns_next | ew_next | (err_sticky & ~clear_err);
        end
    end

endmodule
